ahb_two_master_arbiter: RTL and testbench

Shares the single AHB slave port of the AHB-to-APB bridge between two AHB-lite masters, e.g. a CPU-side master and a DMA-style master.
- Owns bus grant and the address/control mux toward the bridge.
- Tracks data-phase ownership so write data stays with the correct master across a handover.
- Sits between the masters and the bridge's Haddr/Htrans/Hwrite/Hwdata/Hreadyin inputs. Masters receive Hrdata/Hresp/Hreadyout directly from the bridge.

---
 rtl/ahb_two_master_arbiter.sv | 92 +++++++++
 tb/tb_ahb_two_master_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_two_master_arbiter.sv
// Two-master AHB-lite arbiter in front of the AHB-to-APB bridge slave port.
// Default build is two-way round-robin; define ARB_FIXED_PRIO_EN for fixed priority to master 0.
module ahb_two_master_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              Hclk,
   input  logic              Hreset,
   input  logic              Hbusreq0,
   input  logic              Hbusreq1,
   input  logic [1:0]        Htrans0,
   input  logic [1:0]        Htrans1,
   input  logic [ADDR_W-1:0] Haddr0,
   input  logic [ADDR_W-1:0] Haddr1,
   input  logic              Hwrite0,
   input  logic              Hwrite1,
   input  logic [DATA_W-1:0] Hwdata0,
   input  logic [DATA_W-1:0] Hwdata1,
   input  logic              Hreadyout,
   output logic              Hgrant0,
   output logic              Hgrant1,
   output logic              Hmaster,
   output logic [1:0]        Htrans,
   output logic [ADDR_W-1:0] Haddr,
   output logic              Hwrite,
   output logic [DATA_W-1:0] Hwdata,
   output logic              Hreadyin
);

   localparam logic [1:0] TRANS_IDLE = 2'b00;

   typedef enum logic {
      OWN0 = 1'b0,
      OWN1 = 1'b1
   } arb_state_e;

   arb_state_e state_q, state_d;
   logic       data_owner_q, data_owner_d;
   logic [1:0] owner_trans;
   logic       owner_req;
   logic       other_req;
   logic       arb_point;

   always_ff @(posedge Hclk or negedge Hreset) begin
      if (!Hreset) begin
         state_q      <= OWN0;
         data_owner_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_owner_q <= data_owner_d;
      end
   end

   always_comb begin
      owner_trans  = (state_q == OWN1) ? Htrans1 : Htrans0;
      owner_req    = (state_q == OWN1) ? Hbusreq1 : Hbusreq0;
      other_req    = (state_q == OWN1) ? Hbusreq0 : Hbusreq1;
      // Burst beats and wait states keep the bus locked to the current owner.
      arb_point    = Hreadyout && ((owner_trans == TRANS_IDLE) || !owner_req);
      state_d      = state_q;
      data_owner_d = data_owner_q;

`ifdef ARB_FIXED_PRIO_EN
      if (arb_point) begin
         if (Hbusreq0) begin
            state_d = OWN0;
         end else if (Hbusreq1) begin
            state_d = OWN1;
         end
      end
`else
      if (arb_point && other_req) begin
         state_d = (state_q == OWN0) ? OWN1 : OWN0;
      end
`endif

      // The address phase accepted on this edge becomes the data phase being tracked.
      if (Hreadyout) begin
         data_owner_d = (state_q == OWN1);
      end
   end

   assign Hmaster  = (state_q == OWN1);
   assign Hgrant0  = (state_q == OWN0);
   assign Hgrant1  = (state_q == OWN1);
   assign Htrans   = !Hreset ? TRANS_IDLE : (Hmaster ? Htrans1 : Htrans0);
   assign Haddr    = Hmaster ? Haddr1 : Haddr0;
   assign Hwrite   = Hmaster ? Hwrite1 : Hwrite0;
   assign Hwdata   = data_owner_q ? Hwdata1 : Hwdata0;
   assign Hreadyin = Hreadyout;

endmodule

// File: tb/tb_ahb_two_master_arbiter.sv
// Directed bench for ahb_two_master_arbiter (round-robin build).
module tb_ahb_two_master_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              Hclk;
   logic              Hreset;
   logic              Hbusreq0, Hbusreq1;
   logic [1:0]        Htrans0, Htrans1;
   logic [ADDR_W-1:0] Haddr0, Haddr1;
   logic              Hwrite0, Hwrite1;
   logic [DATA_W-1:0] Hwdata0, Hwdata1;
   logic              Hreadyout;
   logic              Hgrant0, Hgrant1, Hmaster;
   logic [1:0]        Htrans;
   logic [ADDR_W-1:0] Haddr;
   logic              Hwrite;
   logic [DATA_W-1:0] Hwdata;
   logic              Hreadyin;

   int errors = 0;
   int checks = 0;

   ahb_two_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .Hclk(Hclk), .Hreset(Hreset),
      .Hbusreq0(Hbusreq0), .Hbusreq1(Hbusreq1),
      .Htrans0(Htrans0), .Htrans1(Htrans1),
      .Haddr0(Haddr0), .Haddr1(Haddr1),
      .Hwrite0(Hwrite0), .Hwrite1(Hwrite1),
      .Hwdata0(Hwdata0), .Hwdata1(Hwdata1),
      .Hreadyout(Hreadyout),
      .Hgrant0(Hgrant0), .Hgrant1(Hgrant1), .Hmaster(Hmaster),
      .Htrans(Htrans), .Haddr(Haddr), .Hwrite(Hwrite),
      .Hwdata(Hwdata), .Hreadyin(Hreadyin)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_m;

      // Reset held with both masters requesting and driving NONSEQ
      Hreset = 1'b0; Hbusreq0 = 1'b1; Hbusreq1 = 1'b1;
      Htrans0 = 2'b10; Htrans1 = 2'b10;
      Haddr0 = '0; Haddr1 = '0; Hwrite0 = 1'b0; Hwrite1 = 1'b0;
      Hwdata0 = '0; Hwdata1 = '0; Hreadyout = 1'b1;
      #1;
      chk("rst_grant0", 64'(Hgrant0), 64'd1);
      chk("rst_htrans", 64'(Htrans), 64'd0);
      tick(); tick();
      chk("rst_grant0_held", 64'(Hgrant0), 64'd1);
      chk("rst_grant1_held", 64'(Hgrant1), 64'd0);
      chk("rst_hmaster_held", 64'(Hmaster), 64'd0);
      chk("rst_htrans_held", 64'(Htrans), 64'd0);

      // Release with both requesting: master 1 wins the first arbitration point
      Hreset = 1'b1; Htrans0 = 2'b00;
      #1;
      chk("rel_hmaster_pre", 64'(Hmaster), 64'd0);
      tick();
      chk("rel_hmaster", 64'(Hmaster), 64'd1);
      chk("rel_grant1", 64'(Hgrant1), 64'd1);
      chk("rel_grant0", 64'(Hgrant0), 64'd0);
      Htrans1 = 2'b10; Haddr1 = 32'h8000_0100;
      #1;
      chk("rel_htrans_mux", 64'(Htrans), 64'd2);
      chk("rel_haddr_mux", 64'(Haddr), 64'h8000_0100);

      // Back to master 0, then a single handover to master 1
      Htrans1 = 2'b00; Hbusreq0 = 1'b1;
      tick();
      chk("back0_hmaster", 64'(Hmaster), 64'd0);
      Hbusreq0 = 1'b0; Htrans0 = 2'b00; Hbusreq1 = 1'b1;
      Haddr1 = 32'h8000_0010; Htrans1 = 2'b10;
      tick();
      chk("ho_grant1", 64'(Hgrant1), 64'd1);
      chk("ho_hmaster", 64'(Hmaster), 64'd1);
      chk("ho_haddr", 64'(Haddr), 64'h8000_0010);

      Htrans1 = 2'b00; Hbusreq1 = 1'b0; Hbusreq0 = 1'b1;
      tick();
      chk("back0b_hmaster", 64'(Hmaster), 64'd0);

      // INCR4 write burst on master 0 with master 1 requesting throughout
      Hbusreq1 = 1'b1; Htrans1 = 2'b10; Hwrite0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Htrans0 = (i == 0) ? 2'b10 : 2'b11;
         Haddr0  = 32'h8000_0000 + 32'(4 * i);
         #1;
         chk($sformatf("burst_haddr%0d", i), 64'(Haddr), 64'(32'h8000_0000 + 32'(4 * i)));
         tick();
         chk($sformatf("burst_lock%0d", i), 64'(Hmaster), 64'd0);
      end
      Htrans0 = 2'b00;
      tick();
      chk("burst_release", 64'(Hmaster), 64'd1);

      // Data-phase split across a handover
      Htrans1 = 2'b00; Hbusreq1 = 1'b0; Hbusreq0 = 1'b1; Htrans0 = 2'b00;
      tick();
      chk("split_own0", 64'(Hmaster), 64'd0);
      Htrans0 = 2'b10; Haddr0 = 32'h8000_0000; Hwrite0 = 1'b1; Hbusreq0 = 1'b0;
      Hbusreq1 = 1'b1; Htrans1 = 2'b10; Haddr1 = 32'h8000_0004; Hwrite1 = 1'b1;
      Hwdata1 = 32'h5A5A_0001;
      tick();
      Hwdata0 = 32'hA5A5_A5A5; Htrans0 = 2'b00;
      #1;
      chk("split_hmaster", 64'(Hmaster), 64'd1);
      chk("split_haddr", 64'(Haddr), 64'h8000_0004);
      chk("split_hwdata_m0", 64'(Hwdata), 64'hA5A5_A5A5);
      Htrans1 = 2'b00;
      tick();
      chk("split_hwdata_m1", 64'(Hwdata), 64'h5A5A_0001);

      // Wait states at a would-be arbitration point
      Hbusreq1 = 1'b0; Hbusreq0 = 1'b1;
      tick();
      chk("ws_own0", 64'(Hmaster), 64'd0);
      Htrans0 = 2'b10; Haddr0 = 32'h8000_0008; Hwrite0 = 1'b1;
      tick();
      Htrans0 = 2'b00; Hbusreq1 = 1'b1; Htrans1 = 2'b10;
      Hreadyout = 1'b0; Hwdata0 = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("ws_hmaster%0d", i), 64'(Hmaster), 64'd0);
         chk($sformatf("ws_hwdata%0d", i), 64'(Hwdata), 64'h1234_5678);
         chk($sformatf("ws_hreadyin%0d", i), 64'(Hreadyin), 64'd0);
      end
      Hreadyout = 1'b1;
      tick();
      chk("ws_switch", 64'(Hmaster), 64'd1);
      chk("ws_hwdata_after", 64'(Hwdata), 64'h1234_5678);
      chk("ws_hreadyin", 64'(Hreadyin), 64'd1);

      // Fairness: both masters do single NONSEQ then IDLE
      Hbusreq0 = 1'b1; Hbusreq1 = 1'b1;
      exp_m = 1'b1;
      for (int i = 0; i < 4; i++) begin
         Htrans0 = 2'b10; Htrans1 = 2'b10;
         tick();
         chk($sformatf("fair_hold%0d", i), 64'(Hmaster), 64'(exp_m));
         Htrans0 = 2'b00; Htrans1 = 2'b00;
         tick();
         exp_m = ~exp_m;
         chk($sformatf("fair_switch%0d", i), 64'(Hmaster), 64'(exp_m));
      end

      // Reset mid-burst while master 1 owns both phases
      Htrans0 = 2'b10; Htrans1 = 2'b10;
      Hwdata0 = 32'hCAFE_0000; Hwdata1 = 32'hBEEF_0000;
      tick();
      chk("midrst_pre_owner", 64'(Hmaster), 64'd1);
      chk("midrst_pre_hwdata", 64'(Hwdata), 64'hBEEF_0000);
      Hreset = 1'b0;
      #1;
      chk("midrst_hmaster", 64'(Hmaster), 64'd0);
      chk("midrst_grant0", 64'(Hgrant0), 64'd1);
      chk("midrst_htrans", 64'(Htrans), 64'd0);
      chk("midrst_hwdata", 64'(Hwdata), 64'hCAFE_0000);
      tick();
      Hreset = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
